idma_dp_req_arbiter: RTL and testbench
======================================

Name: idma_dp_req_arbiter

Overview:
- Shares one transport layer's read and write datapath-request channels between NumPorts backends.
- Round-robin arbitration over paired (read, write) requests; a granted pair is issued atomically, with independent downstream handshakes on each channel.
- Read and write datapath responses are routed back to the originating port in issue order via per-channel ID FIFOs.
- Sits between the backend request splitters and the transport layer's r_dp/w_dp request and response ports.

Parameters:
- NumPorts, 2: number of requesting backends (>=2).
- NumOutstanding, 4: ID FIFO depth per channel; maximum issued-but-unresponded requests per channel (>=1).
- RReqWidth, 32: bit width of one read datapath request.
- WReqWidth, 32: bit width of one write datapath request.
- RRspWidth, 8: bit width of one read datapath response.
- WRspWidth, 8: bit width of one write datapath response.
- IdWidth: derived, max(1, clog2(NumPorts)).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  NumPorts  per-port request pair valid
- req_ready_o  out  NumPorts  per-port grant/accept
- r_req_i  in  NumPorts*RReqWidth  per-port read dp request; port p at slice [p*RReqWidth +: RReqWidth]
- w_req_i  in  NumPorts*WReqWidth  per-port write dp request
- r_dp_req_o  out  RReqWidth  read dp request to transport layer
- r_dp_valid_o  out  1  read dp request valid
- r_dp_ready_i  in  1  read dp request ready
- w_dp_req_o  out  WReqWidth  write dp request to transport layer
- w_dp_valid_o  out  1  write dp request valid
- w_dp_ready_i  in  1  write dp request ready
- r_dp_rsp_i  in  RRspWidth  read dp response from transport layer
- r_dp_rsp_valid_i  in  1  read dp response valid
- r_dp_rsp_ready_o  out  1  read dp response ready
- w_dp_rsp_i  in  WRspWidth  write dp response from transport layer
- w_dp_rsp_valid_i  in  1  write dp response valid
- w_dp_rsp_ready_o  out  1  write dp response ready
- r_rsp_o  out  RRspWidth  read response, broadcast to all ports
- r_rsp_valid_o  out  NumPorts  read response valid, one-hot by owner
- r_rsp_ready_i  in  NumPorts  per-port read response ready
- w_rsp_o  out  WRspWidth  write response, broadcast to all ports
- w_rsp_valid_o  out  NumPorts  write response valid, one-hot by owner
- w_rsp_ready_i  in  NumPorts  per-port write response ready
- busy_o  out  1  any request held or any response outstanding

Behaviour:
- Reset: FSM in IDLE; rr pointer 0; both ID FIFOs empty; request registers 0. All valid and ready outputs are 0 and busy_o=0 while reset is held.
- FSM IDLE:
  - can_grant = both ID FIFOs not full.
  - Winner = first port with req_valid_i set, searching from the rr pointer upward with wrap-around.
  - req_ready_o is one-hot on the winner only, and only if can_grant; it is combinational from req_valid_i.
  - On a grant: register r_req and w_req; push the winner ID into both FIFOs; set rr pointer = winner+1, wrapping to 0 after NumPorts-1; go to ISSUE with r_pend=w_pend=1.
  - With no grant, the pointer holds.
- FSM ISSUE:
  - r_dp_valid_o=r_pend and w_dp_valid_o=w_pend; request outputs come from registers, so request latency is 1 cycle from grant.
  - A handshake clears its pending flag. Once both flags are clear (simultaneous handshakes allowed), go to IDLE.
  - The next grant may occur in that same IDLE cycle, giving back-to-back issue every 2 cycles minimum.
  - Once asserted, valids stay high and data stays stable until accepted.
  - req_ready_o is all 0 in ISSUE.
- Response routing (combinational, zero latency):
  - Read head ID h: r_rsp_valid_o[h]=r_dp_rsp_valid_i & ~r_fifo_empty; r_dp_rsp_ready_o=r_rsp_ready_i[h] & ~r_fifo_empty. Pop on that handshake.
  - Write channel is identical, using its own FIFO.
  - If the matching FIFO is empty: response ready=0 and all valid bits 0. A response arriving with an empty FIFO is a protocol error and is flagged by a simulation assertion.
- FIFO full: a push only occurs when not full, even if a pop happens the same cycle. This is a conservative limit; at most NumOutstanding issued requests per channel.
- busy_o = (state==ISSUE) | ~r_fifo_empty | ~w_fifo_empty.
- Reset mid-operation: pending issues and FIFO contents are discarded immediately, with no handshake completion.
- Assertions: the registered request is stable while its valid is high and ready is low; FIFO push never happens when full; pop never happens when empty.

Test Plan:
- Single port: port 0 raises req with r=0xA, w=0xB. Required: req_ready_o=01 that cycle; next cycle r_dp_req_o=0xA and w_dp_req_o=0xB, both valid. r_dp_ready_i and w_dp_ready_i=1 → return to IDLE; busy_o=1 until both responses are returned to port 0.
- Fairness: ports 0 and 1 both request continuously with immediate downstream ready. Required: grants alternate 0,1,0,1; a new grant every 2 cycles.
- Skewed handshake: w_dp_ready_i held low 5 cycles while r_dp_ready_i=1. Required: r_dp_valid_o drops after 1 cycle; w_dp_valid_o stays high with stable data; no new grant until the write is accepted.
- Outstanding limit (NumOutstanding=4): issue 4 pairs with no responses. Required: 5th request gets req_ready_o=0. One read response and one write response returned → 5th grant the next IDLE cycle.
- Routing order: grants 1,0,1; read responses R1,R2,R3. Required: r_rsp_valid_o=10,01,10 in turn. With r_rsp_ready_i[1]=0, r_dp_rsp_ready_o=0 and the FIFO holds.
- Async reset asserted in ISSUE with 2 outstanding: all valids 0 immediately, busy_o=0. After release, the rr pointer is 0 and port 0 wins first.

Source files
------------

// File: rtl/idma_dp_req_arbiter.sv
// Shares one read/write datapath-request channel pair between NumPorts backends, returns responses in issue order.
// Latency: request out 1 cycle after grant; responses routed combinationally (zero latency).
// Backpressure: grant waits for ISSUE to drain and for room in both ID FIFOs; responses stall on the owner's ready.

// Small ID FIFO: remembers which port owns each issued-but-unresponded request.
// Latency: head visible the cycle after push; pop takes effect at the next edge.
// Backpressure: push ignored when full, pop ignored when empty (the caller never does either).
module idma_dp_req_arbiter_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push, w_pop;

  assign full_o  = (r_cnt == CntW'(Depth));
  assign empty_o = (r_cnt == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the count guards every read.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // Pointers and occupancy count, wrapping at Depth.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);
endmodule

module idma_dp_req_arbiter #(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned RReqWidth      = 32,
  parameter int unsigned WReqWidth      = 32,
  parameter int unsigned RRspWidth      = 8,
  parameter int unsigned WRspWidth      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_valid_i,
  output logic [NumPorts-1:0]           req_ready_o,
  input  logic [NumPorts*RReqWidth-1:0] r_req_i,
  input  logic [NumPorts*WReqWidth-1:0] w_req_i,
  output logic [RReqWidth-1:0]          r_dp_req_o,
  output logic                          r_dp_valid_o,
  input  logic                          r_dp_ready_i,
  output logic [WReqWidth-1:0]          w_dp_req_o,
  output logic                          w_dp_valid_o,
  input  logic                          w_dp_ready_i,
  input  logic [RRspWidth-1:0]          r_dp_rsp_i,
  input  logic                          r_dp_rsp_valid_i,
  output logic                          r_dp_rsp_ready_o,
  input  logic [WRspWidth-1:0]          w_dp_rsp_i,
  input  logic                          w_dp_rsp_valid_i,
  output logic                          w_dp_rsp_ready_o,
  output logic [RRspWidth-1:0]          r_rsp_o,
  output logic [NumPorts-1:0]           r_rsp_valid_o,
  input  logic [NumPorts-1:0]           r_rsp_ready_i,
  output logic [WRspWidth-1:0]          w_rsp_o,
  output logic [NumPorts-1:0]           w_rsp_valid_o,
  input  logic [NumPorts-1:0]           w_rsp_ready_i,
  output logic                          busy_o
);
  localparam int unsigned IdWidth = ($clog2(NumPorts) > 1) ? $clog2(NumPorts) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               r_state, w_state_nxt;
  logic                 r_rd_pend, r_wr_pend, w_rd_pend_nxt, w_wr_pend_nxt;
  logic [RReqWidth-1:0] r_rd_req;
  logic [WReqWidth-1:0] r_wr_req;
  logic [IdWidth-1:0]   r_rr_ptr, w_winner, w_idx;
  logic                 w_found, w_can_grant, w_grant;
  logic [IdWidth-1:0]   w_rd_head, w_wr_head;
  logic                 w_rd_full, w_rd_empty, w_rd_pop;
  logic                 w_wr_full, w_wr_empty, w_wr_pop;

  assign w_can_grant = ~w_rd_full & ~w_wr_full;
  assign r_dp_req_o  = r_rd_req;
  assign w_dp_req_o  = r_wr_req;
  assign busy_o      = (r_state == ISSUE) | ~w_rd_empty | ~w_wr_empty;

  // Round-robin search: first requesting port at or above the pointer, with wrap-around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      w_idx = IdWidth'((32'(r_rr_ptr) + i) % NumPorts);
      if (!w_found && req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // FSM next state and downstream valids; a grant in IDLE loads a full read/write pair.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_pend_nxt = r_rd_pend;
    w_wr_pend_nxt = r_wr_pend;
    w_grant       = 1'b0;
    r_dp_valid_o  = 1'b0;
    w_dp_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant = rst_ni & w_found & w_can_grant;
        if (w_grant) begin
          w_state_nxt   = ISSUE;
          w_rd_pend_nxt = 1'b1;
          w_wr_pend_nxt = 1'b1;
        end
      end
      ISSUE: begin
        r_dp_valid_o = r_rd_pend;
        w_dp_valid_o = r_wr_pend;
        if (r_rd_pend && r_dp_ready_i) w_rd_pend_nxt = 1'b0;
        if (r_wr_pend && w_dp_ready_i) w_wr_pend_nxt = 1'b0;
        if (!w_rd_pend_nxt && !w_wr_pend_nxt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant is one-hot on the winner and only while a pair can actually be taken.
  always_comb begin
    req_ready_o = '0;
    if (w_grant) req_ready_o[w_winner] = 1'b1;
  end

  // State, pending flags, round-robin pointer and captured request pair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_rd_pend <= 1'b0;
      r_wr_pend <= 1'b0;
      r_rr_ptr  <= '0;
      r_rd_req  <= '0;
      r_wr_req  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_wr_pend <= w_wr_pend_nxt;
      if (w_grant) begin
        r_rr_ptr <= (w_winner == IdWidth'(NumPorts - 1)) ? '0 : w_winner + 1'b1;
        r_rd_req <= r_req_i[32'(w_winner)*RReqWidth +: RReqWidth];
        r_wr_req <= w_req_i[32'(w_winner)*WReqWidth +: WReqWidth];
      end
    end
  end

  // Response steering: the FIFO head names the owner; nothing is accepted without an owner.
  always_comb begin
    r_rsp_valid_o = '0;
    w_rsp_valid_o = '0;
    if (r_dp_rsp_valid_i && !w_rd_empty) r_rsp_valid_o[w_rd_head] = 1'b1;
    if (w_dp_rsp_valid_i && !w_wr_empty) w_rsp_valid_o[w_wr_head] = 1'b1;
    r_dp_rsp_ready_o = ~w_rd_empty & r_rsp_ready_i[w_rd_head];
    w_dp_rsp_ready_o = ~w_wr_empty & w_rsp_ready_i[w_wr_head];
  end

  assign r_rsp_o  = r_dp_rsp_i;
  assign w_rsp_o  = w_dp_rsp_i;
  assign w_rd_pop = r_dp_rsp_valid_i & r_dp_rsp_ready_o;
  assign w_wr_pop = w_dp_rsp_valid_i & w_dp_rsp_ready_o;

  idma_dp_req_arbiter_id_fifo #(.Depth(NumOutstanding), .Width(IdWidth)) u_rd_id_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(w_grant), .data_i(w_winner),
    .pop_i(w_rd_pop), .data_o(w_rd_head), .full_o(w_rd_full), .empty_o(w_rd_empty)
  );

  idma_dp_req_arbiter_id_fifo #(.Depth(NumOutstanding), .Width(IdWidth)) u_wr_id_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(w_grant), .data_i(w_winner),
    .pop_i(w_wr_pop), .data_o(w_wr_head), .full_o(w_wr_full), .empty_o(w_wr_empty)
  );

  a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_dp_valid_o && !r_dp_ready_i) |=> (r_dp_valid_o && $stable(r_dp_req_o)));
  a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_dp_valid_o && !w_dp_ready_i) |=> (w_dp_valid_o && $stable(w_dp_req_o)));
  a_r_rsp_owner: assert property (@(posedge clk_i) disable iff (!rst_ni) r_dp_rsp_valid_i |-> !w_rd_empty);
  a_w_rsp_owner: assert property (@(posedge clk_i) disable iff (!rst_ni) w_dp_rsp_valid_i |-> !w_wr_empty);
endmodule

// File: tb/tb_idma_dp_req_arbiter.sv
module tb_idma_dp_req_arbiter;
  localparam int NP = 2;
  localparam int NO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid_i, req_ready_o;
  logic [NP*32-1:0] r_req_i, w_req_i;
  logic [31:0]      r_dp_req_o, w_dp_req_o;
  logic             r_dp_valid_o, r_dp_ready_i, w_dp_valid_o, w_dp_ready_i;
  logic [7:0]       r_dp_rsp_i, w_dp_rsp_i, r_rsp_o, w_rsp_o;
  logic             r_dp_rsp_valid_i, r_dp_rsp_ready_o, w_dp_rsp_valid_i, w_dp_rsp_ready_o;
  logic [NP-1:0]    r_rsp_valid_o, r_rsp_ready_i, w_rsp_valid_o, w_rsp_ready_i;
  logic             busy_o;

  idma_dp_req_arbiter #(.NumPorts(NP), .NumOutstanding(NO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .r_req_i(r_req_i), .w_req_i(w_req_i),
    .r_dp_req_o(r_dp_req_o), .r_dp_valid_o(r_dp_valid_o), .r_dp_ready_i(r_dp_ready_i),
    .w_dp_req_o(w_dp_req_o), .w_dp_valid_o(w_dp_valid_o), .w_dp_ready_i(w_dp_ready_i),
    .r_dp_rsp_i(r_dp_rsp_i), .r_dp_rsp_valid_i(r_dp_rsp_valid_i), .r_dp_rsp_ready_o(r_dp_rsp_ready_o),
    .w_dp_rsp_i(w_dp_rsp_i), .w_dp_rsp_valid_i(w_dp_rsp_valid_i), .w_dp_rsp_ready_o(w_dp_rsp_ready_o),
    .r_rsp_o(r_rsp_o), .r_rsp_valid_o(r_rsp_valid_o), .r_rsp_ready_i(r_rsp_ready_i),
    .w_rsp_o(w_rsp_o), .w_rsp_valid_o(w_rsp_valid_o), .w_rsp_ready_i(w_rsp_ready_i),
    .busy_o(busy_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner queues per channel, round-robin pointer, one held pair.
  int          m_ptr;
  bit          m_issue, m_rp, m_wp;
  logic [31:0] m_rd, m_wd;
  int          rq[$];
  int          wq[$];
  bit          auto_rsp;

  // Observed values captured at the sampling point of the last step.
  logic [NP-1:0] cap_req_ready, cap_r_rsp_valid, cap_w_rsp_valid;
  logic          cap_rv, cap_wv, cap_rrdy, cap_busy;
  logic [31:0]   cap_rreq, cap_wreq;
  logic [31:0]   skew_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict, sample mid-cycle, compare, advance model, move to next edge.
  task automatic step();
    int win, p;
    logic [NP-1:0] e_rdy, e_rv, e_wv;
    logic e_rr, e_wr;
    if (!rst_n) begin
      m_issue = 0; m_rp = 0; m_wp = 0; m_ptr = 0;
      rq.delete(); wq.delete();
    end
    if (auto_rsp) begin
      r_dp_rsp_valid_i = (rq.size() > 0);
      w_dp_rsp_valid_i = (wq.size() > 0);
    end
    win = -1;
    if (rst_n && !m_issue && rq.size() < NO && wq.size() < NO)
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (win < 0 && req_valid_i[p]) win = p;
      end
    e_rdy = '0; if (win >= 0) e_rdy[win] = 1'b1;
    e_rv = '0;  if (r_dp_rsp_valid_i && rq.size() > 0) e_rv[rq[0]] = 1'b1;
    e_wv = '0;  if (w_dp_rsp_valid_i && wq.size() > 0) e_wv[wq[0]] = 1'b1;
    e_rr = (rq.size() > 0) && r_rsp_ready_i[rq[0]];
    e_wr = (wq.size() > 0) && w_rsp_ready_i[wq[0]];
    #2;
    cap_req_ready = req_ready_o; cap_rv = r_dp_valid_o; cap_wv = w_dp_valid_o;
    cap_rreq = r_dp_req_o; cap_wreq = w_dp_req_o; cap_r_rsp_valid = r_rsp_valid_o;
    cap_w_rsp_valid = w_rsp_valid_o; cap_rrdy = r_dp_rsp_ready_o; cap_busy = busy_o;
    chk("req_ready", req_ready_o, e_rdy);
    chk("r_dp_valid", r_dp_valid_o, m_issue && m_rp);
    chk("w_dp_valid", w_dp_valid_o, m_issue && m_wp);
    if (m_issue && m_rp) chk("r_dp_req", r_dp_req_o, m_rd);
    if (m_issue && m_wp) chk("w_dp_req", w_dp_req_o, m_wd);
    chk("r_rsp_valid", r_rsp_valid_o, e_rv);
    chk("w_rsp_valid", w_rsp_valid_o, e_wv);
    chk("r_dp_rsp_ready", r_dp_rsp_ready_o, e_rr);
    chk("w_dp_rsp_ready", w_dp_rsp_ready_o, e_wr);
    if (e_rv != 0) chk("r_rsp_data", r_rsp_o, r_dp_rsp_i);
    if (e_wv != 0) chk("w_rsp_data", w_rsp_o, w_dp_rsp_i);
    chk("busy", busy_o, m_issue || rq.size() > 0 || wq.size() > 0);
    if (rst_n) begin
      if (r_dp_rsp_valid_i && e_rr) void'(rq.pop_front());
      if (w_dp_rsp_valid_i && e_wr) void'(wq.pop_front());
      if (m_issue) begin
        if (r_dp_ready_i) m_rp = 0;
        if (w_dp_ready_i) m_wp = 0;
        if (!m_rp && !m_wp) m_issue = 0;
      end else if (win >= 0) begin
        m_rd = r_req_i[win*32 +: 32];
        m_wd = w_req_i[win*32 +: 32];
        rq.push_back(win); wq.push_back(win);
        m_ptr = (win + 1) % NP;
        m_issue = 1; m_rp = 1; m_wp = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input int n);
    auto_rsp = 1; req_valid_i = '0; r_rsp_ready_i = '1; w_rsp_ready_i = '1;
    repeat (n) step();
    auto_rsp = 0; r_dp_rsp_valid_i = 0; w_dp_rsp_valid_i = 0;
  endtask

  initial begin
    req_valid_i = '0; r_req_i = '0; w_req_i = '0;
    r_dp_ready_i = 0; w_dp_ready_i = 0;
    r_dp_rsp_i = '0; w_dp_rsp_i = '0; r_dp_rsp_valid_i = 0; w_dp_rsp_valid_i = 0;
    r_rsp_ready_i = '0; w_rsp_ready_i = '0; auto_rsp = 0;
    m_ptr = 0; m_issue = 0; m_rp = 0; m_wp = 0; m_rd = '0; m_wd = '0;
    @(posedge clk); #1;

    // Reset held: requests present but nothing may be granted.
    req_valid_i = 2'b11;
    step(); step();
    chk("rst_req_ready", cap_req_ready, 2'b00);
    chk("rst_busy", cap_busy, 1'b0);
    rst_n = 1; req_valid_i = '0;
    step();

    // Single port 0.
    r_req_i = {32'h0, 32'hA}; w_req_i = {32'h0, 32'hB};
    r_dp_ready_i = 1; w_dp_ready_i = 1; req_valid_i = 2'b01;
    step();
    chk("t1_grant", cap_req_ready, 2'b01);
    req_valid_i = '0;
    step();
    chk("t1_rreq", cap_rreq, 32'hA); chk("t1_wreq", cap_wreq, 32'hB);
    chk("t1_rv", cap_rv, 1'b1);      chk("t1_wv", cap_wv, 1'b1);
    step();
    chk("t1_busy_out", cap_busy, 1'b1);
    r_dp_rsp_i = 8'h5A; r_dp_rsp_valid_i = 1; r_rsp_ready_i = 2'b01; w_rsp_ready_i = 2'b01;
    step();
    chk("t1_rsp_r", cap_r_rsp_valid, 2'b01);
    r_dp_rsp_valid_i = 0; w_dp_rsp_i = 8'hC3; w_dp_rsp_valid_i = 1;
    step();
    chk("t1_busy_w", cap_busy, 1'b1);
    chk("t1_rsp_w", cap_w_rsp_valid, 2'b01);
    w_dp_rsp_valid_i = 0;
    step();
    chk("t1_idle", cap_busy, 1'b0);

    // Fairness: both ports request continuously, pointer currently at 1.
    r_req_i = {32'h1111_0001, 32'h0000_0010}; w_req_i = {32'h2222_0001, 32'h0000_0020};
    auto_rsp = 1; r_rsp_ready_i = '1; w_rsp_ready_i = '1; req_valid_i = 2'b11;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("fair_grant", cap_req_ready, (i % 2) ? 2'b00 : ((i % 4 == 0) ? 2'b10 : 2'b01));
    end

    // Skewed handshake: write held off for 5 cycles.
    w_dp_ready_i = 0; skew_w = w_req_i[63:32];
    step();
    chk("skew_grant", cap_req_ready, 2'b10);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("skew_rv", cap_rv, (i == 0));
      chk("skew_wv", cap_wv, 1'b1);
      chk("skew_wdata", cap_wreq, skew_w);
      chk("skew_nogrant", cap_req_ready, 2'b00);
    end
    w_dp_ready_i = 1;
    step();
    chk("skew_wlast", cap_req_ready, 2'b00);
    step();
    chk("skew_next", cap_req_ready, 2'b01);
    req_valid_i = '0;
    step();
    drain(6);

    // Outstanding limit.
    req_valid_i = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("lim_fill", cap_req_ready, (i % 2) ? 2'b00 : 2'b01);
    end
    step(); chk("lim_block0", cap_req_ready, 2'b00);
    step(); chk("lim_block1", cap_req_ready, 2'b00);
    r_dp_rsp_valid_i = 1; r_rsp_ready_i = '1; w_rsp_ready_i = '1;
    step(); chk("lim_after_r", cap_req_ready, 2'b00);
    r_dp_rsp_valid_i = 0; w_dp_rsp_valid_i = 1;
    step(); chk("lim_after_w", cap_req_ready, 2'b00);
    w_dp_rsp_valid_i = 0;
    step(); chk("lim_5th", cap_req_ready, 2'b01);
    req_valid_i = '0;
    step();
    drain(6);

    // Routing order: grants 1,0,1 then read responses.
    req_valid_i = 2'b10; step(); chk("rt_g1", cap_req_ready, 2'b10);
    req_valid_i = 2'b00; step();
    req_valid_i = 2'b01; step(); chk("rt_g0", cap_req_ready, 2'b01);
    req_valid_i = 2'b00; step();
    req_valid_i = 2'b10; step(); chk("rt_g2", cap_req_ready, 2'b10);
    req_valid_i = 2'b00; step();
    r_dp_rsp_valid_i = 1; r_rsp_ready_i = 2'b11;
    step(); chk("rt_r1", cap_r_rsp_valid, 2'b10);
    step(); chk("rt_r2", cap_r_rsp_valid, 2'b01);
    r_rsp_ready_i = 2'b01;
    step(); chk("rt_r3_stall", cap_r_rsp_valid, 2'b10); chk("rt_stall_rdy", cap_rrdy, 1'b0);
    step(); chk("rt_r3_hold", cap_r_rsp_valid, 2'b10);
    r_rsp_ready_i = 2'b11;
    step(); chk("rt_r3_go", cap_rrdy, 1'b1);
    r_dp_rsp_valid_i = 0;
    drain(6);

    // Async reset in ISSUE with two outstanding.
    r_dp_ready_i = 1; w_dp_ready_i = 1;
    req_valid_i = 2'b01; step();
    req_valid_i = 2'b00; step();
    req_valid_i = 2'b10; step();
    req_valid_i = 2'b00; r_dp_ready_i = 0; w_dp_ready_i = 0; step();
    chk("mr_issue", cap_rv, 1'b1);
    rst_n = 0;
    step();
    chk("mr_rv", cap_rv, 1'b0); chk("mr_wv", cap_wv, 1'b0); chk("mr_busy", cap_busy, 1'b0);
    rst_n = 1; r_dp_ready_i = 1; w_dp_ready_i = 1; req_valid_i = 2'b11;
    step(); chk("mr_first", cap_req_ready, 2'b01);
    req_valid_i = '0; step();
    drain(4);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      req_valid_i = NP'($urandom);
      r_req_i = {$urandom, $urandom}; w_req_i = {$urandom, $urandom};
      r_dp_ready_i = ($urandom_range(0, 2) != 0);
      w_dp_ready_i = ($urandom_range(0, 2) != 0);
      r_dp_rsp_i = 8'($urandom); w_dp_rsp_i = 8'($urandom);
      r_dp_rsp_valid_i = rst_n && rq.size() > 0 && ($urandom_range(0, 1) == 1);
      w_dp_rsp_valid_i = rst_n && wq.size() > 0 && ($urandom_range(0, 1) == 1);
      r_rsp_ready_i = NP'($urandom); w_rsp_ready_i = NP'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
